// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, block types and permutation helpers shared by encrypt/decrypt
package des_pkg;

    typedef logic [63:0] des_blk_t;
    typedef logic [31:0] des_half_t;
    typedef logic [27:0] des_cd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} des_state_t;

    // All tables use DES bit numbering: bit 1 is the MSB of the source vector.
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    // S-boxes, each 4 rows x 16 columns flattened row-major
    localparam int SBOX [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    function automatic des_blk_t ip_perm(input des_blk_t x);
        des_blk_t r;
        r = '0;
        for (int i = 0; i < 64; i++) r = {r[62:0], x[6'(64 - IP_T[i])]};
        return r;
    endfunction

    function automatic des_blk_t fp_perm(input des_blk_t x);
        des_blk_t r;
        r = '0;
        for (int i = 0; i < 64; i++) r = {r[62:0], x[6'(64 - FP_T[i])]};
        return r;
    endfunction

    function automatic logic [47:0] e_exp(input des_half_t x);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r = {r[46:0], x[5'(32 - E_T[i])]};
        return r;
    endfunction

    function automatic des_half_t p_perm(input des_half_t x);
        des_half_t r;
        r = '0;
        for (int i = 0; i < 32; i++) r = {r[30:0], x[5'(32 - P_T[i])]};
        return r;
    endfunction

    function automatic logic [55:0] pc1_perm(input des_blk_t x);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r = {r[54:0], x[6'(64 - PC1_T[i])]};
        return r;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r = {r[46:0], x[6'(56 - PC2_T[i])]};
        return r;
    endfunction

    // Row is the outer bit pair of each 6-bit group, column the inner four bits
    function automatic des_half_t sbox_sub(input logic [47:0] x);
        des_half_t   r;
        logic [5:0]  b;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            b = 6'(x >> (42 - 6 * i));
            r = {r[27:0], 4'(SBOX[3'(i)][{b[5], b[0], b[4:1]}])};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_f.sv
// rtl/des_f.sv - combinational DES round function f(R,K) = P(S(E(R) xor K))
module des_f
    import des_pkg::*;
(
    input  des_half_t   r,
    input  logic [47:0] k,
    output des_half_t   f
);

    assign f = p_perm(sbox_sub(e_exp(r) ^ k));

endmodule

// File: rtl/des_decrypt_iter.sv
// rtl/des_decrypt_iter.sv - iterative DES decryptor, one Feistel round per clock
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter bit CHECK_PARITY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  des_blk_t    encrypted_data,
    input  des_blk_t    key,
    output logic        out_valid,
    input  logic        out_ready,
    output des_blk_t    plain_text,
    output logic        key_parity_err,
    output logic        busy
);

    des_state_t  state, state_nxt;
    logic [4:0]  rnd;
    des_half_t   l_q, r_q, f_out;
    des_cd_t     c_q, d_q, c_rot, d_rot;
    logic [47:0] subkey;
    logic        par_bad, par_q;

    // Decryption walks the schedule backwards: round 1 uses C16D16 (= C0D0) as loaded,
    // later rounds undo the encryptor's left shifts by rotating right.
    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        if (rnd >= 5'd2 && rnd <= 5'd16) begin
            if (SHIFT_T[4'(17 - rnd)] == 2) begin
                c_rot = {c_q[1:0], c_q[27:2]};
                d_rot = {d_q[1:0], d_q[27:2]};
            end else begin
                c_rot = {c_q[0], c_q[27:1]};
                d_rot = {d_q[0], d_q[27:1]};
            end
        end
    end

    assign subkey = pc2_perm({c_rot, d_rot});

    des_f u_f (
        .r (r_q),
        .k (subkey),
        .f (f_out)
    );

    // Any key byte with even parity flags an error when checking is enabled
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (~^key[6'(8 * i) +: 8]) par_bad = 1'b1;
        end
        if (!CHECK_PARITY) par_bad = 1'b0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid)        state_nxt = ST_ROUND;
            ST_ROUND: if (rnd == 5'd16)    state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)       state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

    // Datapath: load on accept, one round per cycle, capture result after round 16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q            <= '0;
            r_q            <= '0;
            c_q            <= '0;
            d_q            <= '0;
            rnd            <= '0;
            par_q          <= 1'b0;
            plain_text     <= '0;
            key_parity_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        {l_q, r_q} <= ip_perm(encrypted_data);
                        {c_q, d_q} <= pc1_perm(key);
                        rnd        <= 5'd1;
                        par_q      <= par_bad;
                    end
                end
                ST_ROUND: begin
                    l_q <= r_q;
                    r_q <= l_q ^ f_out;
                    c_q <= c_rot;
                    d_q <= d_rot;
                    rnd <= rnd + 5'd1;
                    if (rnd == 5'd16) begin
                        plain_text     <= fp_perm({l_q ^ f_out, r_q});
                        key_parity_err <= par_q;
                        rnd            <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb/tb_des_decrypt_iter.sv - randomized self-checking bench for des_decrypt_iter
module tb_des_decrypt_iter;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] encrypted_data;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plain_text;
    logic        key_parity_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    des_decrypt_iter #(.CHECK_PARITY(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .encrypted_data (encrypted_data),
        .key            (key),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .plain_text     (plain_text),
        .key_parity_err (key_parity_err),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // DES bit n (1 = MSB) of a w-bit value
    function automatic logic gb(input logic [63:0] v, input int w, input int n);
        logic [63:0] t;
        t = v >> (w - n);
        return t[0];
    endfunction

    // Textbook DES: forward key schedule with left shifts, subkeys reversed for decryption
    function automatic logic [63:0] model_des(input logic [63:0] blk, input logic [63:0] k, input bit dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] x;
        logic [63:0] t, y;
        logic [31:0] l, r, s, p, nr;
        logic [5:0]  six;
        cd = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], gb(k, 64, PC1_T[i])};
        c = cd[55:28];
        d = cd[27:0];
        for (int rd = 0; rd < 16; rd++) begin
            for (int s_i = 0; s_i < SHIFT_T[rd]; s_i++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            x = '0;
            for (int j = 0; j < 48; j++) x = {x[46:0], gb({8'h0, c, d}, 56, PC2_T[j])};
            ks[rd] = x;
        end
        t = '0;
        for (int i = 0; i < 64; i++) t = {t[62:0], gb(blk, 64, IP_T[i])};
        l = t[63:32];
        r = t[31:0];
        for (int rd = 0; rd < 16; rd++) begin
            x = '0;
            for (int j = 0; j < 48; j++) x = {x[46:0], gb({32'h0, r}, 32, E_T[j])};
            x = x ^ (dec ? ks[15 - rd] : ks[rd]);
            s = '0;
            for (int b = 0; b < 8; b++) begin
                six = 6'(x >> (42 - 6 * b));
                s = {s[27:0], 4'(SBOX[b][{six[5], six[0], six[4:1]}])};
            end
            p = '0;
            for (int j = 0; j < 32; j++) p = {p[30:0], gb({32'h0, s}, 32, P_T[j])};
            nr = l ^ p;
            l  = r;
            r  = nr;
        end
        t = {r, l};
        y = '0;
        for (int i = 0; i < 64; i++) y = {y[62:0], gb(t, 64, FP_T[i])};
        return y;
    endfunction

    function automatic logic exp_parity(input logic [63:0] k);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 8; i++) if ($countones(k >> (8 * i) & 64'hFF) % 2 == 0) e = 1'b1;
        return e;
    endfunction

    task automatic accept(input logic [63:0] k, input logic [63:0] ct);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_timeout", 64'd0, 64'd1);
        key            = k;
        encrypted_data = ct;
        in_valid       = 1'b1;
        @(posedge clk);
        #1;
        in_valid       = 1'b0;
        key            = {$urandom, $urandom};
        encrypted_data = {$urandom, $urandom};
    endtask

    task automatic wait_result(output int lat);
        bit ok;
        lat = 0;
        ok  = 1'b0;
        while (lat < 40 && !ok) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) check("result_timeout", 64'd0, 64'd1);
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("take_out_valid", out_valid, 1'b0);
        check("take_in_ready", in_ready, 1'b1);
    endtask

    task automatic run_one(input string tag, input logic [63:0] k, input logic [63:0] ct,
                           input logic [63:0] exp_pt, input bit chk_lat);
        int lat;
        accept(k, ct);
        wait_result(lat);
        if (chk_lat) check({tag, "_latency"}, lat, 16);
        check({tag, "_pt"}, plain_text, exp_pt);
        check({tag, "_perr"}, key_parity_err, exp_parity(k));
        take();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] k, pt, ct, held;
        int          lat;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        encrypted_data = '0; key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_pt", plain_text, 64'h0);
        check("rst_perr", key_parity_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Known-answer vectors and single-block loopback
        run_one("kat1", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b1);
        run_one("kat2", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 1'b1);
        ct = model_des(64'h6565656565656565, 64'h6565656565656565, 1'b0);
        run_one("loop65", 64'h6565656565656565, ct, 64'h6565656565656565, 1'b1);

        // Backpressure: result held, extra InValid ignored while DONE
        accept(64'h133457799BBCDFF1, 64'h85E813540F0AB405);
        wait_result(lat);
        held = plain_text;
        check("bp_busy", busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_pt_stable", plain_text, 64'h0123456789ABCDEF);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            if (i == 2) begin
                in_valid       = 1'b1;
                key            = {$urandom, $urandom};
                encrypted_data = {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        check("bp_pt_held", plain_text, held);
        take();
        run_one("bp_next", 64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 1'b1);

        // Bad key parity still decrypts
        k = 64'h133457799BBCDFF0;
        run_one("parity", k, 64'h85E813540F0AB405, model_des(64'h85E813540F0AB405, k, 1'b1), 1'b1);
        check("parity_model", {63'h0, exp_parity(k)}, 64'd1);

        // Asynchronous reset mid-computation
        accept(64'h0E329232EA6D0D73, 64'h0000000000000000);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_pt", plain_text, 64'h0);
        check("arst_perr", key_parity_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one("arst_next", 64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1'b1);

        // Random round trips through the reference encryptor
        for (int n = 0; n < 200; n++) begin
            k  = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            ct = model_des(pt, k, 1'b0);
            run_one("rand", k, ct, pt, (n % 20) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
